preg_freelist: RTL

- Circular free list of physical destination registers, shared between the two dispatch slots; sits beside the busy table in the issue/rename stage.
- Dispatch pops up to 2 pregs/cycle; these are the pregs the busy table marks busy.
- Commit pushes up to 2 stale (old) pregs/cycle back.
- On ROB rollback, speculative allocations are discarded by restoring the head to the architectural head; during walk, the head is re-advanced for each walked instruction.

---
 rtl/preg_freelist_pkg.sv | 31 +++
 rtl/preg_freelist_if.sv | 40 ++++
 rtl/preg_freelist_ptr.sv | 46 ++++
 rtl/preg_freelist.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/preg_freelist_pkg.sv
// ----------------------------------------------------------------------------
// preg_freelist_pkg
// Definitions shared by the free list, the busy table and the ROB: register
// file sizing, free-list pointer geometry and the ROB state encoding.
// Optional build macro FREELIST_CHECK_EN (used by preg_freelist) enables the
// sticky consistency checker.
// ----------------------------------------------------------------------------
package preg_freelist_pkg;

    localparam int PREGS     = 64;                  // physical registers
    localparam int ARCH_REGS = 32;                  // mapped at reset
    localparam int PREG_W    = 6;                   // preg index width
    localparam int DEPTH     = PREGS - ARCH_REGS;   // free-list entries
    localparam int IDX_W     = $clog2(DEPTH);       // entry index width
    localparam int PTR_W     = IDX_W + 1;           // MSB is the wrap bit

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [PTR_W-1:0]  fl_ptr_t;

    typedef enum logic [1:0] {
        ROB_STATE_IDLE      = 2'd0,
        ROB_STATE_ROLLIBACK = 2'd1,
        ROB_STATE_WALK      = 2'd2
    } rob_state_e;

    // Number of set bits in a pair of slot enables (0, 1 or 2).
    function automatic logic [1:0] count2(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/preg_freelist_if.sv
// ----------------------------------------------------------------------------
// preg_freelist_if
// Bundles the dispatch allocation, commit free and ROB recovery signals of the
// physical-register free list.
//   master : dispatch/ROB side (drives requests, frees, rob_state, walk)
//   slave  : the free list (drives grants, alloc_ready, free_count, error)
// ----------------------------------------------------------------------------
interface preg_freelist_if;
    import preg_freelist_pkg::*;

    logic       alloc_req0;
    logic       alloc_req1;
    logic       alloc_ready;
    preg_t      alloc_prd0;
    preg_t      alloc_prd1;
    logic       commit_free_en0;
    logic       commit_free_en1;
    preg_t      commit_old_prd0;
    preg_t      commit_old_prd1;
    rob_state_e rob_state;
    logic       walking_valid0;
    logic       walking_valid1;
    fl_ptr_t    free_count;
    logic       freelist_err;

    modport master (
        output alloc_req0, alloc_req1,
        output commit_free_en0, commit_free_en1, commit_old_prd0, commit_old_prd1,
        output rob_state, walking_valid0, walking_valid1,
        input  alloc_ready, alloc_prd0, alloc_prd1, free_count, freelist_err
    );

    modport slave (
        input  alloc_req0, alloc_req1,
        input  commit_free_en0, commit_free_en1, commit_old_prd0, commit_old_prd1,
        input  rob_state, walking_valid0, walking_valid1,
        output alloc_ready, alloc_prd0, alloc_prd1, free_count, freelist_err
    );

endinterface

// File: rtl/preg_freelist_ptr.sv
// ----------------------------------------------------------------------------
// freelist_ptr
// Wrap-bit ring pointer register used for the free-list head, tail and
// architectural head.
//   clock    : clock
//   reset    : asynchronous, active-high reset (loads RESET_VAL)
//   inc      : advance by 0, 1 or 2 entries this cycle
//   load     : synchronous load of load_val (takes priority over inc)
//   load_val : value loaded when load is high
//   ptr      : current pointer value
// ----------------------------------------------------------------------------
module freelist_ptr
    import preg_freelist_pkg::*;
#(
    parameter fl_ptr_t RESET_VAL = '0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] inc,
    input  logic       load,
    input  fl_ptr_t    load_val,
    output fl_ptr_t    ptr
);

    fl_ptr_t ptr_reg;
    fl_ptr_t ptr_next;

    // The wrap bit falls out of plain modulo-2^PTR_W addition.
    always_comb begin
        ptr_next = ptr_reg + fl_ptr_t'(inc);
        if (load) begin
            ptr_next = load_val;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_reg <= RESET_VAL;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/preg_freelist.sv
// ----------------------------------------------------------------------------
// preg_freelist
// Circular free list of physical destination registers shared by the two
// dispatch slots. Dispatch pops up to two pregs per cycle, commit pushes up to
// two stale pregs back. On ROB rollback the head snaps back to the
// architectural head and is re-advanced during the walk, so the walked
// instructions get back the same pregs they were originally granted.
//
// Ports:
//   clock : clock
//   reset : asynchronous, active-high reset
//   fl    : preg_freelist_if.slave
//           alloc_req0/1, alloc_ready, alloc_prd0/1        - allocation
//           commit_free_en0/1, commit_old_prd0/1           - commit frees
//           rob_state, walking_valid0/1                    - ROB recovery
//           free_count                                     - tail - head
//           freelist_err                                   - sticky error
//
// Build option: FREELIST_CHECK_EN builds a sticky checker that flags
// over-full pushes, walks past the tail and inconsistent rollbacks on
// freelist_err. Without it freelist_err is constant 0.
// ----------------------------------------------------------------------------
module preg_freelist
    import preg_freelist_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    preg_freelist_if.slave  fl
);

    preg_t          queue_reg [DEPTH];

    fl_ptr_t        head;
    fl_ptr_t        tail;
    fl_ptr_t        arch_head;
    fl_ptr_t        arch_head_next;
    fl_ptr_t        free_count;

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] head1_idx;
    logic [IDX_W-1:0] tail_idx;
    logic [IDX_W-1:0] tail1_idx;

    logic           is_idle;
    logic           is_rollback;
    logic           is_walk;
    logic           alloc_ready;
    logic [1:0]     pop_cnt;
    logic [1:0]     push_cnt;
    logic [1:0]     walk_cnt;
    logic [1:0]     head_inc;

    assign is_idle     = (fl.rob_state == ROB_STATE_IDLE);
    assign is_rollback = (fl.rob_state == ROB_STATE_ROLLIBACK);
    assign is_walk     = (fl.rob_state == ROB_STATE_WALK);

    // Readiness is judged on registered pointers only; frees landing this
    // cycle are not visible until the next one.
    assign free_count  = tail - head;
    assign alloc_ready = is_idle && (free_count >= fl_ptr_t'(2));

    assign pop_cnt  = alloc_ready ? count2(fl.alloc_req0, fl.alloc_req1) : 2'd0;
    assign push_cnt = count2(fl.commit_free_en0, fl.commit_free_en1);
    assign walk_cnt = count2(fl.walking_valid0, fl.walking_valid1);

    // Every freed old preg retires one committed allocation, so the
    // architectural head moves with the push count in every ROB state.
    assign arch_head_next = arch_head + fl_ptr_t'(push_cnt);

    always_comb begin
        head_inc = 2'd0;
        case (fl.rob_state)
            ROB_STATE_IDLE: head_inc = pop_cnt;
            ROB_STATE_WALK: head_inc = walk_cnt;
            default:        head_inc = 2'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Pointers
    // ------------------------------------------------------------------
    freelist_ptr #(.RESET_VAL(fl_ptr_t'(0))) u_head (
        .clock    (clock),
        .reset    (reset),
        .inc      (head_inc),
        .load     (is_rollback),
        .load_val (arch_head_next),
        .ptr      (head)
    );

    freelist_ptr #(.RESET_VAL(fl_ptr_t'(DEPTH))) u_tail (
        .clock    (clock),
        .reset    (reset),
        .inc      (push_cnt),
        .load     (1'b0),
        .load_val (fl_ptr_t'(0)),
        .ptr      (tail)
    );

    freelist_ptr #(.RESET_VAL(fl_ptr_t'(0))) u_arch_head (
        .clock    (clock),
        .reset    (reset),
        .inc      (push_cnt),
        .load     (1'b0),
        .load_val (fl_ptr_t'(0)),
        .ptr      (arch_head)
    );

    // ------------------------------------------------------------------
    // Entry storage. Each entry has a distinct reset value (the unmapped
    // pregs ARCH_REGS..PREGS-1), so it is built from flops, not RAM.
    // ------------------------------------------------------------------
    assign head_idx  = head[IDX_W-1:0];
    assign head1_idx = head_idx + IDX_W'(1);
    assign tail_idx  = tail[IDX_W-1:0];
    assign tail1_idx = tail_idx + IDX_W'(fl.commit_free_en0);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    queue_reg[gi] <= PREG_W'(ARCH_REGS + gi);
                end else if (fl.commit_free_en0 && (tail_idx == IDX_W'(gi))) begin
                    queue_reg[gi] <= fl.commit_old_prd0;
                end else if (fl.commit_free_en1 && (tail1_idx == IDX_W'(gi))) begin
                    queue_reg[gi] <= fl.commit_old_prd1;
                end
            end
        end
    endgenerate

    // Slot 1 takes the head entry when slot 0 is idle, keeping grants dense.
    // Reads use pre-edge contents, so an entry written this cycle is never
    // granted in the same cycle.
    assign fl.alloc_prd0  = queue_reg[head_idx];
    assign fl.alloc_prd1  = fl.alloc_req0 ? queue_reg[head1_idx] : queue_reg[head_idx];
    assign fl.alloc_ready = alloc_ready;
    assign fl.free_count  = free_count;

    // ------------------------------------------------------------------
    // Optional consistency checker
    // ------------------------------------------------------------------
`ifdef FREELIST_CHECK_EN
    logic           err_reg;
    logic [PTR_W:0] fill_after;
    logic [PTR_W:0] fill_limit;
    logic           push_over;
    logic           walk_over;
    logic           rollback_bad;

    always_comb begin
        fill_after   = {1'b0, free_count} + (PTR_W+1)'(push_cnt);
        fill_limit   = (PTR_W+1)'(DEPTH) + (PTR_W+1)'(head_inc);
        push_over    = (push_cnt != 2'd0) && (fill_after > fill_limit);
        walk_over    = is_walk && (fl_ptr_t'(walk_cnt) > free_count);
        // The architectural head must sit in the allocated span, i.e. going
        // round the ring from the tail it is reached no later than the head:
        // head - arch_head can never exceed the allocated count.
        rollback_bad = is_rollback &&
                       ((head - arch_head) > (fl_ptr_t'(DEPTH) - free_count));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if (push_over || walk_over || rollback_bad) begin
            err_reg <= 1'b1;
        end
    end

    assign fl.freelist_err = err_reg;
`else
    assign fl.freelist_err = 1'b0;
`endif

endmodule
